// File: rtl/bcrypt_axi4_burst_slave.sv
// bcrypt_axi4_burst_slave
//   AXI4 full-protocol memory-mapped slave backed by a word-wide RAM.
//   Supports FIXED/INCR/WRAP bursts, WSTRB byte enables, ID reflection and
//   SLVERR reporting. The write and read channels are independent FSMs, each
//   with one transaction outstanding.
//
// Ports
//   ACLK, ARESETN                     : clock, async active-low reset
//   AW* / W* / B*                     : write address, data and response channels
//   AR* / R*                          : read address and data channels
//
// Write FSM
//   state  | meaning
//   W_IDLE | AWREADY high, waiting for a write address
//   W_DATA | WREADY high, accepting AWLEN+1 beats
//   W_RESP | BVALID high until BREADY
//
// Read FSM
//   state  | meaning
//   R_IDLE | ARREADY high, waiting for a read address
//   R_DATA | RVALID high, presenting ARLEN+1 beats
module bcrypt_axi4_burst_slave #(
  parameter int C_S_AXI_ID_WIDTH   = 4,
  parameter int C_S_AXI_DATA_WIDTH = 32,
  parameter int C_S_AXI_ADDR_WIDTH = 12,
  parameter int C_MEM_DEPTH_LOG2   = 8
) (
  input  logic                            ACLK,
  input  logic                            ARESETN,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     AWID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   AWADDR,
  input  logic [7:0]                      AWLEN,
  input  logic [2:0]                      AWSIZE,
  input  logic [1:0]                      AWBURST,
  input  logic                            AWVALID,
  output logic                            AWREADY,
  input  logic [C_S_AXI_DATA_WIDTH-1:0]   WDATA,
  input  logic [C_S_AXI_DATA_WIDTH/8-1:0] WSTRB,
  input  logic                            WLAST,
  input  logic                            WVALID,
  output logic                            WREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     BID,
  output logic [1:0]                      BRESP,
  output logic                            BVALID,
  input  logic                            BREADY,
  input  logic [C_S_AXI_ID_WIDTH-1:0]     ARID,
  input  logic [C_S_AXI_ADDR_WIDTH-1:0]   ARADDR,
  input  logic [7:0]                      ARLEN,
  input  logic [2:0]                      ARSIZE,
  input  logic [1:0]                      ARBURST,
  input  logic                            ARVALID,
  output logic                            ARREADY,
  output logic [C_S_AXI_ID_WIDTH-1:0]     RID,
  output logic [C_S_AXI_DATA_WIDTH-1:0]   RDATA,
  output logic [1:0]                      RRESP,
  output logic                            RLAST,
  output logic                            RVALID,
  input  logic                            RREADY
);

  localparam int AW       = C_S_AXI_ADDR_WIDTH;
  localparam int DW       = C_S_AXI_DATA_WIDTH;
  localparam int IW       = C_S_AXI_ID_WIDTH;
  localparam int DL       = C_MEM_DEPTH_LOG2;
  localparam int NBYTES   = DW / 8;
  localparam int ADDR_LSB = $clog2(NBYTES);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] BURST_WRAP  = 2'b10;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} w_state_t;
  typedef enum logic       {R_IDLE, R_DATA}         r_state_t;

  // Address arithmetic is done in 32 bits so that oversized bursts (which are
  // errors anyway) cannot overflow the comparison.
  function automatic logic [AW-1:0] align_addr(input logic [AW-1:0] a,
                                               input logic [2:0]    size);
    logic [31:0] mask;
    logic [31:0] res;
    mask = (32'd1 << size) - 32'd1;
    res  = 32'(a) & ~mask;
    return res[AW-1:0];
  endfunction

  function automatic logic [AW-1:0] next_addr(input logic [AW-1:0] a,
                                              input logic [2:0]    size,
                                              input logic [7:0]    len,
                                              input logic [1:0]    burst);
    logic [31:0] a32;
    logic [31:0] incr;
    logic [31:0] lbytes;
    logic [31:0] res;
    a32    = 32'(a);
    incr   = 32'd1 << size;
    lbytes = (32'(len) + 32'd1) << size;
    case (burst)
      BURST_FIXED: res = a32;
      // Keep the bits above the wrap window, let the offset roll over inside it.
      BURST_WRAP:  res = (a32 & ~(lbytes - 32'd1)) | ((a32 + incr) & (lbytes - 32'd1));
      default:     res = a32 + incr;
    endcase
    return res[AW-1:0];
  endfunction

  function automatic logic burst_err(input logic [AW-1:0] a,
                                     input logic [2:0]    size,
                                     input logic [7:0]    len,
                                     input logic [1:0]    burst);
    logic [31:0] lbytes;
    logic [31:0] start;
    logic        err;
    lbytes = (32'(len) + 32'd1) << size;
    start  = 32'(align_addr(a, size)) & 32'h0000_0FFF;
    err    = 1'b0;
    if (int'(size) > ADDR_LSB) err = 1'b1;
    case (burst)
      2'b11:      err = 1'b1;
      BURST_WRAP: if (!(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15)) err = 1'b1;
      BURST_INCR: if (start + lbytes > 32'h0000_1000) err = 1'b1;
      default:    ;
    endcase
    return err;
  endfunction

  // Ready flags must stay low until the first edge after reset release.
  logic rst_done;
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) rst_done <= 1'b0;
    else          rst_done <= 1'b1;
  end

  logic [DW-1:0] mem [2**DL];

  // ---------------------------------------------------------------- write
  w_state_t      w_state, w_next;
  logic          aw_hs, w_beat;
  logic [IW-1:0] w_id;
  logic [AW-1:0] w_addr;
  logic [7:0]    w_len, w_cnt;
  logic [2:0]    w_size;
  logic [1:0]    w_burst;
  logic          w_aerr, w_lerr;
  logic [DL-1:0] w_idx;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) w_state <= W_IDLE;
    else          w_state <= w_next;
  end

  always_comb begin
    w_next  = w_state;
    aw_hs   = 1'b0;
    w_beat  = 1'b0;
    AWREADY = 1'b0;
    WREADY  = 1'b0;
    BVALID  = 1'b0;
    case (w_state)
      W_IDLE: begin
        AWREADY = rst_done;
        if (AWVALID && rst_done) begin
          aw_hs  = 1'b1;
          w_next = W_DATA;
        end
      end
      W_DATA: begin
        WREADY = 1'b1;
        if (WVALID) begin
          w_beat = 1'b1;
          if (w_cnt == w_len) w_next = W_RESP;
        end
      end
      W_RESP: begin
        BVALID = 1'b1;
        if (BREADY) w_next = W_IDLE;
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      w_id    <= '0;
      w_addr  <= '0;
      w_len   <= '0;
      w_size  <= '0;
      w_burst <= '0;
      w_aerr  <= 1'b0;
      w_lerr  <= 1'b0;
      w_cnt   <= '0;
    end else if (aw_hs) begin
      w_id    <= AWID;
      w_addr  <= align_addr(AWADDR, AWSIZE);
      w_len   <= AWLEN;
      w_size  <= AWSIZE;
      w_burst <= AWBURST;
      w_aerr  <= burst_err(AWADDR, AWSIZE, AWLEN, AWBURST);
      w_lerr  <= 1'b0;
      w_cnt   <= '0;
    end else if (w_beat) begin
      // The beat count terminates the burst; WLAST only feeds the error flag.
      if (WLAST != (w_cnt == w_len)) w_lerr <= 1'b1;
      w_cnt  <= w_cnt + 8'd1;
      w_addr <= next_addr(w_addr, w_size, w_len, w_burst);
    end
  end

  assign w_idx = w_addr[ADDR_LSB +: DL];
  assign BID   = w_id;
  assign BRESP = (BVALID && (w_aerr || w_lerr)) ? RESP_SLVERR : 2'b00;

  // Memory has no reset; only a legal burst may modify it.
  always_ff @(posedge ACLK) begin
    if (w_beat && !w_aerr) begin
      for (int b = 0; b < NBYTES; b++) begin
        if (WSTRB[b]) mem[w_idx][8*b +: 8] <= WDATA[8*b +: 8];
      end
    end
  end

  // ----------------------------------------------------------------- read
  r_state_t      r_state, r_next;
  logic          ar_hs, r_adv;
  logic [IW-1:0] r_id;
  logic [AW-1:0] r_addr;
  logic [7:0]    r_len, r_cnt;
  logic [2:0]    r_size;
  logic [1:0]    r_burst;
  logic          r_err;
  logic [DW-1:0] r_data;
  logic [AW-1:0] ar_start, r_nxt;
  logic          ar_err;
  logic [DL-1:0] ar_idx, r_nxt_idx;

  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= R_IDLE;
    else          r_state <= r_next;
  end

  always_comb begin
    r_next  = r_state;
    ar_hs   = 1'b0;
    r_adv   = 1'b0;
    ARREADY = 1'b0;
    RVALID  = 1'b0;
    RLAST   = 1'b0;
    case (r_state)
      R_IDLE: begin
        ARREADY = rst_done;
        if (ARVALID && rst_done) begin
          ar_hs  = 1'b1;
          r_next = R_DATA;
        end
      end
      R_DATA: begin
        RVALID = 1'b1;
        RLAST  = (r_cnt == r_len);
        if (RREADY) begin
          if (r_cnt == r_len) r_next = R_IDLE;
          else                r_adv  = 1'b1;
        end
      end
      default: r_next = R_IDLE;
    endcase
  end

  assign ar_start  = align_addr(ARADDR, ARSIZE);
  assign ar_err    = burst_err(ARADDR, ARSIZE, ARLEN, ARBURST);
  assign ar_idx    = ar_start[ADDR_LSB +: DL];
  assign r_nxt     = next_addr(r_addr, r_size, r_len, r_burst);
  assign r_nxt_idx = r_nxt[ADDR_LSB +: DL];

  // RDATA is registered from the memory on the handshake edge, so a write to
  // the same word on that edge is not yet visible (read-old-data).
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_id    <= '0;
      r_addr  <= '0;
      r_len   <= '0;
      r_size  <= '0;
      r_burst <= '0;
      r_err   <= 1'b0;
      r_cnt   <= '0;
      r_data  <= '0;
    end else if (ar_hs) begin
      r_id    <= ARID;
      r_addr  <= ar_start;
      r_len   <= ARLEN;
      r_size  <= ARSIZE;
      r_burst <= ARBURST;
      r_err   <= ar_err;
      r_cnt   <= '0;
      r_data  <= ar_err ? '0 : mem[ar_idx];
    end else if (r_adv) begin
      r_addr <= r_nxt;
      r_cnt  <= r_cnt + 8'd1;
      r_data <= r_err ? '0 : mem[r_nxt_idx];
    end
  end

  assign RID   = r_id;
  assign RDATA = r_data;
  assign RRESP = (RVALID && r_err) ? RESP_SLVERR : 2'b00;

endmodule

// File: tb/tb_bcrypt_axi4_burst_slave.sv
module tb_bcrypt_axi4_burst_slave;

  logic        ACLK = 1'b0;
  logic        ARESETN;
  logic [3:0]  AWID;
  logic [11:0] AWADDR;
  logic [7:0]  AWLEN;
  logic [2:0]  AWSIZE;
  logic [1:0]  AWBURST;
  logic        AWVALID;
  logic        AWREADY;
  logic [31:0] WDATA;
  logic [3:0]  WSTRB;
  logic        WLAST;
  logic        WVALID;
  logic        WREADY;
  logic [3:0]  BID;
  logic [1:0]  BRESP;
  logic        BVALID;
  logic        BREADY;
  logic [3:0]  ARID;
  logic [11:0] ARADDR;
  logic [7:0]  ARLEN;
  logic [2:0]  ARSIZE;
  logic [1:0]  ARBURST;
  logic        ARVALID;
  logic        ARREADY;
  logic [3:0]  RID;
  logic [31:0] RDATA;
  logic [1:0]  RRESP;
  logic        RLAST;
  logic        RVALID;
  logic        RREADY;

  bcrypt_axi4_burst_slave dut (
    .ACLK(ACLK), .ARESETN(ARESETN),
    .AWID(AWID), .AWADDR(AWADDR), .AWLEN(AWLEN), .AWSIZE(AWSIZE), .AWBURST(AWBURST),
    .AWVALID(AWVALID), .AWREADY(AWREADY),
    .WDATA(WDATA), .WSTRB(WSTRB), .WLAST(WLAST), .WVALID(WVALID), .WREADY(WREADY),
    .BID(BID), .BRESP(BRESP), .BVALID(BVALID), .BREADY(BREADY),
    .ARID(ARID), .ARADDR(ARADDR), .ARLEN(ARLEN), .ARSIZE(ARSIZE), .ARBURST(ARBURST),
    .ARVALID(ARVALID), .ARREADY(ARREADY),
    .RID(RID), .RDATA(RDATA), .RRESP(RRESP), .RLAST(RLAST), .RVALID(RVALID), .RREADY(RREADY)
  );

  always #5 ACLK = ~ACLK;

  typedef struct {
    bit              is_wr;
    logic [3:0]      id;
    logic [11:0]     addr;
    logic [7:0]      len;
    logic [2:0]      size;
    logic [1:0]      burst;
    logic [3:0]      strb;
    int              early;   // beat index carrying WLAST, -1 for normal
    bit              stall;   // RREADY pattern 1,0,0,1
    logic [1:0]      resp;
    logic [7:0][31:0] d;      // write data or expected read data
  } vec_t;

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic logic [7:0][31:0] dv(input logic [31:0] a0, a1, a2, a3, a4, a5, a6, a7);
    logic [7:0][31:0] r;
    r[0] = a0; r[1] = a1; r[2] = a2; r[3] = a3;
    r[4] = a4; r[5] = a5; r[6] = a6; r[7] = a7;
    return r;
  endfunction

  function automatic vec_t mk(input bit wr, input int id, input int addr, input int len,
                              input int size, input int burst, input int strb, input int early,
                              input bit stall, input int resp, input logic [7:0][31:0] d);
    vec_t t;
    t.is_wr = wr;       t.id    = 4'(id);     t.addr = 12'(addr);
    t.len   = 8'(len);  t.size  = 3'(size);   t.burst = 2'(burst);
    t.strb  = 4'(strb); t.early = early;      t.stall = stall;
    t.resp  = 2'(resp); t.d     = d;
    return t;
  endfunction

  task automatic do_write(input int op, input vec_t t);
    int to;
    @(posedge ACLK); #1;
    AWID = t.id; AWADDR = t.addr; AWLEN = t.len; AWSIZE = t.size; AWBURST = t.burst;
    AWVALID = 1'b1;
    @(negedge ACLK);
    to = 0;
    while (!AWREADY && to < 50) begin @(negedge ACLK); to++; end
    check($sformatf("op%0d awready", op), 32'(AWREADY), 32'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int i = 0; i <= int'(t.len); i++) begin
      WDATA  = t.d[i];
      WSTRB  = t.strb;
      WLAST  = (t.early >= 0) ? (i == t.early) : (i == int'(t.len));
      WVALID = 1'b1;
      @(negedge ACLK);
      to = 0;
      while (!WREADY && to < 50) begin @(negedge ACLK); to++; end
      if (!WREADY) check($sformatf("op%0d wready beat%0d", op, i), 32'(WREADY), 32'd1);
      @(posedge ACLK); #1;
    end
    WVALID = 1'b0; WLAST = 1'b0; BREADY = 1'b1;
    @(negedge ACLK);
    check($sformatf("op%0d bvalid after last beat", op), 32'(BVALID), 32'd1);
    to = 0;
    while (!BVALID && to < 50) begin @(negedge ACLK); to++; end
    check($sformatf("op%0d bid", op), 32'(BID), 32'(t.id));
    check($sformatf("op%0d bresp", op), 32'(BRESP), 32'(t.resp));
    @(posedge ACLK); #1;
    BREADY = 1'b0;
  endtask

  task automatic do_read(input int op, input vec_t t);
    int to, k, beat;
    bit have_prev;
    logic [31:0] prev_d;
    logic prev_l;
    @(posedge ACLK); #1;
    ARID = t.id; ARADDR = t.addr; ARLEN = t.len; ARSIZE = t.size; ARBURST = t.burst;
    ARVALID = 1'b1;
    @(negedge ACLK);
    to = 0;
    while (!ARREADY && to < 50) begin @(negedge ACLK); to++; end
    check($sformatf("op%0d arready", op), 32'(ARREADY), 32'd1);
    @(posedge ACLK); #1;
    ARVALID = 1'b0;
    k = 0; beat = 0; have_prev = 0; prev_d = '0; prev_l = 1'b0;
    while (beat <= int'(t.len) && k < 200) begin
      RREADY = t.stall ? ((k % 4 == 0) || (k % 4 == 3)) : 1'b1;
      @(negedge ACLK);
      if (k == 0) check($sformatf("op%0d rvalid first", op), 32'(RVALID), 32'd1);
      if (have_prev) begin
        check($sformatf("op%0d stall rdata", op), RDATA, prev_d);
        check($sformatf("op%0d stall rlast", op), 32'(RLAST), 32'(prev_l));
        have_prev = 0;
      end
      if (RVALID) begin
        if (RREADY) begin
          check($sformatf("op%0d beat%0d rdata", op, beat), RDATA, t.d[beat]);
          check($sformatf("op%0d beat%0d rresp", op, beat), 32'(RRESP), 32'(t.resp));
          check($sformatf("op%0d beat%0d rid", op, beat), 32'(RID), 32'(t.id));
          check($sformatf("op%0d beat%0d rlast", op, beat), 32'(RLAST),
                32'(beat == int'(t.len)));
          beat++;
        end else begin
          prev_d = RDATA; prev_l = RLAST; have_prev = 1;
        end
      end
      @(posedge ACLK); #1;
      k++;
    end
    RREADY = 1'b0;
    check($sformatf("op%0d beat count", op), 32'(beat), 32'(int'(t.len) + 1));
    @(negedge ACLK);
    check($sformatf("op%0d rvalid after last", op), 32'(RVALID), 32'd0);
    check($sformatf("op%0d arready after last", op), 32'(ARREADY), 32'd1);
  endtask

  vec_t v[24];
  int   nv;

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    vec_t t;
    int to;
    ARESETN = 1'b0;
    AWID = '0; AWADDR = '0; AWLEN = '0; AWSIZE = '0; AWBURST = '0; AWVALID = 1'b0;
    WDATA = '0; WSTRB = '0; WLAST = 1'b0; WVALID = 1'b0; BREADY = 1'b0;
    ARID = '0; ARADDR = '0; ARLEN = '0; ARSIZE = '0; ARBURST = '0; ARVALID = 1'b0;
    RREADY = 1'b0;

    nv = 0;
    v[nv++] = mk(1, 3, 'h000, 7, 2, 1, 'hF, -1, 0, 0, dv(1, 2, 3, 4, 5, 6, 7, 8));
    v[nv++] = mk(0, 3, 'h000, 7, 2, 1, 0, -1, 0, 0, dv(1, 2, 3, 4, 5, 6, 7, 8));
    v[nv++] = mk(0, 5, 'h000, 7, 2, 1, 0, -1, 1, 0, dv(1, 2, 3, 4, 5, 6, 7, 8));
    v[nv++] = mk(1, 1, 'h008, 3, 2, 2, 'hF, -1, 0, 0,
                 dv('hA0A0_A0A1, 'hB0B0_B0B2, 'hC0C0_C0C3, 'hD0D0_D0D4, 0, 0, 0, 0));
    v[nv++] = mk(0, 2, 'h000, 3, 2, 1, 0, -1, 0, 0,
                 dv('hC0C0_C0C3, 'hD0D0_D0D4, 'hA0A0_A0A1, 'hB0B0_B0B2, 0, 0, 0, 0));
    v[nv++] = mk(1, 4, 'h010, 0, 2, 1, 'hF, -1, 0, 0, dv('hFFFF_FFFF, 0, 0, 0, 0, 0, 0, 0));
    v[nv++] = mk(1, 4, 'h010, 0, 2, 1, 'h5, -1, 0, 0, dv('h1234_5678, 0, 0, 0, 0, 0, 0, 0));
    v[nv++] = mk(0, 5, 'h010, 0, 2, 1, 0, -1, 0, 0, dv('hFF34_FF78, 0, 0, 0, 0, 0, 0, 0));
    v[nv++] = mk(1, 6, 'h020, 3, 2, 0, 'hF, -1, 0, 0, dv(1, 2, 3, 4, 0, 0, 0, 0));
    v[nv++] = mk(0, 6, 'h020, 0, 2, 1, 0, -1, 0, 0, dv(4, 0, 0, 0, 0, 0, 0, 0));
    v[nv++] = mk(1, 7, 'h040, 1, 2, 1, 'hF, -1, 0, 0, dv('h11, 'h22, 0, 0, 0, 0, 0, 0));
    v[nv++] = mk(1, 7, 'h040, 1, 3, 1, 'hF, -1, 0, 2, dv('hDEAD_BEEF, 'hDEAD_BEEF, 0, 0, 0, 0, 0, 0));
    v[nv++] = mk(0, 7, 'h040, 1, 2, 1, 0, -1, 0, 0, dv('h11, 'h22, 0, 0, 0, 0, 0, 0));
    v[nv++] = mk(0, 8, 'h040, 1, 2, 3, 0, -1, 0, 2, dv(0, 0, 0, 0, 0, 0, 0, 0));
    v[nv++] = mk(1, 2, 'h060, 3, 2, 1, 'hF, 1, 0, 2, dv(1, 2, 3, 4, 0, 0, 0, 0));
    v[nv++] = mk(1, 2, 'h070, 2, 2, 2, 'hF, -1, 0, 2, dv(1, 2, 3, 0, 0, 0, 0, 0));
    v[nv++] = mk(1, 3, 'hFF8, 3, 2, 1, 'hF, -1, 0, 2, dv(9, 9, 9, 9, 0, 0, 0, 0));
    v[nv++] = mk(1, 3, 'hFF8, 1, 2, 1, 'hF, -1, 0, 0, dv('h55, 'h66, 0, 0, 0, 0, 0, 0));
    v[nv++] = mk(0, 3, 'hFF8, 1, 2, 1, 0, -1, 0, 0, dv('h55, 'h66, 0, 0, 0, 0, 0, 0));
    v[nv++] = mk(0, 4, 'hFF8, 3, 2, 1, 0, -1, 0, 2, dv(0, 0, 0, 0, 0, 0, 0, 0));

    // Reset values
    #3;
    check("reset awready", 32'(AWREADY), 32'd0);
    check("reset arready", 32'(ARREADY), 32'd0);
    check("reset wready", 32'(WREADY), 32'd0);
    check("reset bvalid", 32'(BVALID), 32'd0);
    check("reset rvalid", 32'(RVALID), 32'd0);
    check("reset rlast", 32'(RLAST), 32'd0);
    check("reset rdata", RDATA, 32'd0);
    check("reset bresp", 32'(BRESP), 32'd0);
    repeat (2) @(negedge ACLK);
    ARESETN = 1'b1;
    #1;
    check("awready before first edge", 32'(AWREADY), 32'd0);
    @(negedge ACLK);
    check("awready after release", 32'(AWREADY), 32'd1);
    check("arready after release", 32'(ARREADY), 32'd1);

    for (int i = 0; i < nv; i++) begin
      if (v[i].is_wr) do_write(i, v[i]);
      else            do_read(i, v[i]);
    end

    // Reset during beat 4 of an 8-beat write
    @(posedge ACLK); #1;
    AWID = 4'd9; AWADDR = 12'h080; AWLEN = 8'd7; AWSIZE = 3'd2; AWBURST = 2'b01;
    AWVALID = 1'b1;
    @(negedge ACLK);
    to = 0;
    while (!AWREADY && to < 50) begin @(negedge ACLK); to++; end
    check("rst seq awready", 32'(AWREADY), 32'd1);
    @(posedge ACLK); #1;
    AWVALID = 1'b0;
    for (int i = 0; i < 3; i++) begin
      WDATA = 32'h100 + 32'(i); WSTRB = 4'hF; WLAST = 1'b0; WVALID = 1'b1;
      @(negedge ACLK);
      check($sformatf("rst seq wready beat%0d", i), 32'(WREADY), 32'd1);
      @(posedge ACLK); #1;
    end
    WDATA = 32'h103;
    @(negedge ACLK); #1;
    ARESETN = 1'b0;
    #1;
    check("rst seq wready drop", 32'(WREADY), 32'd0);
    check("rst seq bvalid", 32'(BVALID), 32'd0);
    check("rst seq awready low", 32'(AWREADY), 32'd0);
    check("rst seq bid", 32'(BID), 32'd0);
    @(posedge ACLK); #1;
    WVALID = 1'b0;
    @(negedge ACLK);
    ARESETN = 1'b1;
    @(negedge ACLK);
    check("rst seq awready back", 32'(AWREADY), 32'd1);

    t = mk(0, 1, 'h080, 2, 2, 1, 0, -1, 0, 0, dv('h100, 'h101, 'h102, 0, 0, 0, 0, 0));
    do_read(100, t);
    t = mk(1, 10, 'h080, 7, 2, 1, 'hF, -1, 0, 0,
           dv('h200, 'h201, 'h202, 'h203, 'h204, 'h205, 'h206, 'h207));
    do_write(101, t);
    t.is_wr = 0;
    do_read(102, t);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
